pipe_stall_ctrl: RTL and testbench

// - Hazard scheduler for the 5-stage MIPS pipeline. Decides each cycle whether F/D hold and E takes a bubble.
// - Stall sources: register data hazards (Tuse/Tnew) and the multi-cycle mult/div unit.
// - Holds the mult/div busy state machine.
// - Outputs drive the PC enable, the D pipeline-register enable and the E pipeline-register clear.
//   The E->M register itself is never stalled.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/md_busy_counter.sv | 67 ++++++
 rtl/pipe_stall_ctrl.sv | 68 ++++++
 tb/tb_pipe_stall_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard scheduler.
// Tuse/Tnew encodings, the mult/div FSM state type, and default unit latencies.
// The hazard helper encodes the producer/consumer timing rule in one place.
package pipe_ctrl_pkg;

  // Stages until a source operand is consumed
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Stages until a producer's result becomes forwardable
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // A consumer must wait when it reads a live register that its producer
  // cannot deliver by the time the consumer needs it. $0 is hardwired zero.
  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM with a down-counter of remaining cycles.
// Latency: busy asserts one cycle after the start edge and lasts exactly N cycles.
// No backpressure; a start while busy (other than on the final cycle) is dropped and flagged.
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done,
  output logic o_overlap
);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_overlap;
  logic [CNT_W-1:0] w_load;

  // Counter preload: remaining busy cycles after the first one
  assign w_load = i_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  // FSM, counter and registered done/overlap flags; done is precomputed so it
  // is high exactly in the cycle where the counter reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_overlap <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_state <= BUSY;
          r_cnt   <= w_load;
          r_done  <= (w_load == '0);
        end
      end else if (r_cnt == '0) begin
        // Final busy cycle: a start here chains seamlessly into a new operation
        if (i_start) begin
          r_cnt  <= w_load;
          r_done <= (w_load == '0);
        end else begin
          r_state <= IDLE;
        end
      end else begin
        r_cnt  <= r_cnt - CNT_W'(1);
        r_done <= (r_cnt == CNT_W'(1));
        if (i_start) begin
          r_overlap <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = (r_state == BUSY);
  assign o_done    = r_done;
  assign o_overlap = r_overlap;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard scheduler: decides each cycle whether F/D hold and E takes a bubble.
// Latency: stall is combinational from current inputs and mult/div state (same cycle).
// Stall is the backpressure itself; the E->M register is never held.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_is_md,
  input  logic [4:0] e_rd,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_rd,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       md_busy,
  output logic       md_done,
  output logic       md_overlap
);

  logic w_data_stall;
  logic w_md_stall;
  logic w_stall;
  logic w_md_busy;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md (
    .clk       (clk),
    .reset     (reset),
    .i_start   (e_md_start),
    .i_is_div  (e_md_is_div),
    .o_busy    (w_md_busy),
    .o_done    (md_done),
    .o_overlap (md_overlap)
  );

  // Both source operands checked against both in-flight producers
  always_comb begin
    w_data_stall = hazard(d_rs, d_tuse_rs, e_rd, e_tnew)
                 | hazard(d_rs, d_tuse_rs, m_rd, m_tnew)
                 | hazard(d_rt, d_tuse_rt, e_rd, e_tnew)
                 | hazard(d_rt, d_tuse_rt, m_rd, m_tnew);
  end

  // HI/LO users wait while the unit is occupied or being started right now
  assign w_md_stall = d_is_md & (w_md_busy | e_md_start);
  assign w_stall    = w_data_stall | w_md_stall;

  assign stall_f = w_stall;
  assign stall_d = w_stall;
  assign flush_e = w_stall;
  assign md_busy = w_md_busy;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, hand sequences, random vs model.
module tb_pipe_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_rd, m_rd;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_is_md, e_md_start, e_md_is_div;
  logic       stall_f, stall_d, flush_e, md_busy, md_done, md_overlap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_is_md(d_is_md), .e_rd(e_rd), .e_tnew(e_tnew), .m_rd(m_rd), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .md_done(md_done), .md_overlap(md_overlap)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] erd;
    logic [1:0] etnew;
    logic [4:0] mrd;
    logic [1:0] mtnew;
    logic       is_md;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, ".stall_f"}, stall_f, exp);
    check({name, ".stall_d"}, stall_d, exp);
    check({name, ".flush_e"}, flush_e, exp);
  endtask

  task automatic idle_inputs();
    d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 0;
    e_rd = 0; e_tnew = 0; m_rd = 0; m_tnew = 0; e_md_start = 0; e_md_is_div = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  // Reference: an operand waits while any matching producer needs more stages than it has
  function automatic logic ref_operand_wait(input logic [4:0] r, input logic [1:0] tuse,
                                            input logic [4:0] erd, input logic [1:0] etnew,
                                            input logic [4:0] mrd, input logic [1:0] mtnew);
    int ready_in = 0;
    if (r == 0) return 1'b0;
    if (r == erd && int'(etnew) > ready_in) ready_in = int'(etnew);
    if (r == mrd && int'(mtnew) > ready_in) ready_in = int'(mtnew);
    return ready_in > int'(tuse);
  endfunction

  initial begin
    reset = 1'b1;
    idle_inputs();

    //            rs  rt  tuse_rs tuse_rt erd etnew mrd mtnew is_md exp
    vecs[0] = '{5'd8,  5'd0,  2'd1, 2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b0, 1'b1}; // load-use
    vecs[1] = '{5'd8,  5'd0,  2'd1, 2'd3, 5'd8,  2'd1, 5'd0, 2'd0, 1'b0, 1'b0}; // resolved
    vecs[2] = '{5'd0,  5'd0,  2'd0, 2'd0, 5'd0,  2'd2, 5'd0, 2'd1, 1'b0, 1'b0}; // $0 never
    vecs[3] = '{5'd0,  5'd5,  2'd3, 2'd0, 5'd0,  2'd0, 5'd5, 2'd1, 1'b0, 1'b1}; // rt vs M
    vecs[4] = '{5'd0,  5'd5,  2'd3, 2'd1, 5'd0,  2'd0, 5'd5, 2'd1, 1'b0, 1'b0}; // rt in time
    vecs[5] = '{5'd3,  5'd0,  2'd3, 2'd3, 5'd3,  2'd2, 5'd3, 2'd1, 1'b0, 1'b0}; // unused op
    vecs[6] = '{5'd3,  5'd0,  2'd0, 2'd3, 5'd3,  2'd1, 5'd0, 2'd0, 1'b0, 1'b1}; // branch use
    vecs[7] = '{5'd3,  5'd0,  2'd0, 2'd3, 5'd4,  2'd2, 5'd7, 2'd1, 1'b0, 1'b0}; // no match
    vecs[8] = '{5'd0,  5'd31, 2'd3, 2'd1, 5'd31, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1}; // rt vs E
    vecs[9] = '{5'd0,  5'd0,  2'd3, 2'd3, 5'd0,  2'd0, 5'd0, 2'd0, 1'b1, 1'b0}; // md idle

    next_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset.md_busy", md_busy, 1'b0);
    check("reset.md_done", md_done, 1'b0);
    check("reset.md_overlap", md_overlap, 1'b0);
    check_stall("reset", 1'b0);
    next_cycle();

    // Combinational hazard vectors
    for (int i = 0; i < 10; i++) begin
      d_rs = vecs[i].rs; d_rt = vecs[i].rt;
      d_tuse_rs = vecs[i].tuse_rs; d_tuse_rt = vecs[i].tuse_rt;
      e_rd = vecs[i].erd; e_tnew = vecs[i].etnew;
      m_rd = vecs[i].mrd; m_tnew = vecs[i].mtnew; d_is_md = vecs[i].is_md;
      @(negedge clk);
      check_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
      next_cycle();
    end
    idle_inputs();

    // Mult, no waiting consumer: busy t1..t5, done t5
    e_md_start = 1; e_md_is_div = 0;
    for (int k = 0; k <= MULT_N + 1; k++) begin
      @(negedge clk);
      check($sformatf("mult.busy.t%0d", k), md_busy, (k >= 1 && k <= MULT_N));
      check($sformatf("mult.done.t%0d", k), md_done, (k == MULT_N));
      check_stall($sformatf("mult.t%0d", k), 1'b0);
      next_cycle();
      e_md_start = 0;
    end

    // Div with mflo waiting in D: stall t0..t10
    d_is_md = 1; e_md_start = 1; e_md_is_div = 1;
    for (int k = 0; k <= DIV_N + 1; k++) begin
      @(negedge clk);
      check_stall($sformatf("div.t%0d", k), (k <= DIV_N));
      check($sformatf("div.done.t%0d", k), md_done, (k == DIV_N));
      next_cycle();
      e_md_start = 0;
    end
    idle_inputs();

    // Back-to-back mults: second start on the done cycle
    e_md_start = 1;
    for (int k = 0; k <= 2 * MULT_N + 1; k++) begin
      @(negedge clk);
      check($sformatf("b2b.busy.t%0d", k), md_busy, (k >= 1 && k <= 2 * MULT_N));
      check($sformatf("b2b.done.t%0d", k), md_done, (k == MULT_N || k == 2 * MULT_N));
      check($sformatf("b2b.ovl.t%0d", k), md_overlap, 1'b0);
      next_cycle();
      e_md_start = (k + 1 == MULT_N);
    end
    e_md_start = 0;

    // Reset during t3 of a div
    e_md_start = 1; e_md_is_div = 1;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rstdiv.busy.t3", md_busy, 1'b1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rstdiv.busy.t4", md_busy, 1'b0);
    check("rstdiv.done.t4", md_done, 1'b0);
    next_cycle();

    // Mult afterwards runs the full length; a start at t2 is flagged and ignored
    e_md_start = 1; e_md_is_div = 0;
    for (int k = 0; k <= MULT_N + 1; k++) begin
      @(negedge clk);
      check($sformatf("ovl.busy.t%0d", k), md_busy, (k >= 1 && k <= MULT_N));
      check($sformatf("ovl.done.t%0d", k), md_done, (k == MULT_N));
      check($sformatf("ovl.flag.t%0d", k), md_overlap, (k >= 3));
      next_cycle();
      e_md_start = (k + 1 == 2);
      e_md_is_div = (k + 1 == 2);
    end
    idle_inputs();

    // Randomized run against a cycle-indexed model of the busy window
    do_reset();
    begin
      int   b_lo = 1, b_hi = 0;
      logic m_ovl = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        logic exp_busy, exp_stall, in_reset;
        int   n;
        d_rs = 5'($urandom_range(0, 3));
        d_rt = 5'($urandom_range(0, 3));
        d_tuse_rs = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
        d_tuse_rt = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
        e_rd = 5'($urandom_range(0, 3));
        e_tnew = 2'($urandom_range(0, 2));
        m_rd = 5'($urandom_range(0, 3));
        m_tnew = 2'($urandom_range(0, 1));
        d_is_md = ($urandom_range(0, 2) == 0);
        e_md_start = ($urandom_range(0, 5) == 0);
        e_md_is_div = $urandom_range(0, 1) != 0;
        in_reset = ($urandom_range(0, 59) == 0);
        reset = in_reset;
        @(negedge clk);
        exp_busy = (cyc >= b_lo && cyc <= b_hi);
        exp_stall = ref_operand_wait(d_rs, d_tuse_rs, e_rd, e_tnew, m_rd, m_tnew)
                  | ref_operand_wait(d_rt, d_tuse_rt, e_rd, e_tnew, m_rd, m_tnew)
                  | (d_is_md & (exp_busy | e_md_start));
        check($sformatf("rnd%0d.busy", cyc), md_busy, exp_busy);
        check($sformatf("rnd%0d.done", cyc), md_done, exp_busy && cyc == b_hi);
        check($sformatf("rnd%0d.ovl", cyc), md_overlap, m_ovl);
        check_stall($sformatf("rnd%0d", cyc), exp_stall);
        if (in_reset) begin
          b_lo = 1; b_hi = 0; m_ovl = 0;
        end else if (e_md_start) begin
          if (!exp_busy || cyc == b_hi) begin
            n = e_md_is_div ? DIV_N : MULT_N;
            b_lo = cyc + 1;
            b_hi = cyc + n;
          end else begin
            m_ovl = 1;
          end
        end
        next_cycle();
      end
    end
    reset = 1'b0;
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
